// File: rtl/datapath_seq_pkg.sv
// Shared definitions for datapath_seq: opcode values, sequencer states,
// bus source indices and the opcode-to-ALU-operation mapping.
package datapath_seq_pkg;

  localparam logic [2:0] OP_MV  = 3'd0;
  localparam logic [2:0] OP_MVI = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_NOP = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    T1   = 2'd1,
    T2   = 2'd2,
    T3   = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    ALU_NONE = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_OR   = 3'd4,
    ALU_XOR  = 3'd5
  } alu_op_e;

  // Bit positions inside the one-hot bus source vector; all-zero drives 0.
  localparam int BUS_SRC_W = 3;
  localparam int SRC_REG   = 0;
  localparam int SRC_IMM   = 1;
  localparam int SRC_G     = 2;

  function automatic alu_op_e alu_op_of(input logic [2:0] op);
    alu_op_e res;
    case (op)
      OP_ADD:  res = ALU_ADD;
      OP_SUB:  res = ALU_SUB;
      OP_AND:  res = ALU_AND;
      OP_OR:   res = ALU_OR;
      OP_XOR:  res = ALU_XOR;
      default: res = ALU_NONE;
    endcase
    return res;
  endfunction

  function automatic logic is_alu_op(input logic [2:0] op);
    return (alu_op_of(op) != ALU_NONE);
  endfunction

endpackage

// File: rtl/dp_regfile.sv
// General-purpose register file: one synchronous write port, an operand read
// port feeding the bus and a debug read port, both combinational.
module dp_regfile
  import datapath_seq_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  localparam int SEL_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [SEL_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [SEL_W-1:0]  op_idx,
  output logic [DATA_W-1:0] op_data,
  input  logic [SEL_W-1:0]  dbg_idx,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[wr_idx] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign op_data  = regs_q[op_idx];
  assign dbg_data = regs_q[dbg_idx];

endmodule

// File: rtl/datapath_seq.sv
// Multi-cycle bus datapath: register file, accumulator A, ALU, result G and
// flags, sequenced one instruction per run handshake over a one-hot bus mux.
module datapath_seq
  import datapath_seq_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  localparam int SEL_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [2:0]        opcode,
  input  logic [SEL_W-1:0]  rx,
  input  logic [SEL_W-1:0]  ry,
  input  logic [DATA_W-1:0] imm,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] bus,
  output logic              flag_z,
  output logic              flag_c,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [DATA_W-1:0] rd_data
);

  state_e state_q, state_d;

  logic [2:0]        ir_op_q, ir_op_d;
  logic [SEL_W-1:0]  ir_rx_q, ir_rx_d;
  logic [SEL_W-1:0]  ir_ry_q, ir_ry_d;
  logic [DATA_W-1:0] ir_imm_q, ir_imm_d;

  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] g_q, g_d;
  logic              z_q, z_d;
  logic              c_q, c_d;

  logic                 capture;
  logic                 load_a;
  logic                 load_g;
  logic                 rf_we;
  logic [BUS_SRC_W-1:0] bus_src;
  logic [SEL_W-1:0]     op_idx;
  logic [DATA_W-1:0]    op_data;

  logic [DATA_W:0]   alu_wide;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;

  dp_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (rf_we),
    .wr_idx   (ir_rx_q),
    .wr_data  (bus),
    .op_idx   (op_idx),
    .op_data  (op_data),
    .dbg_idx  (rd_sel),
    .dbg_data (rd_data)
  );

  // Sequencer: every step picks exactly one bus source and the loads it feeds.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    load_a  = 1'b0;
    load_g  = 1'b0;
    rf_we   = 1'b0;
    done    = 1'b0;
    bus_src = '0;
    op_idx  = ir_ry_q;

    unique case (state_q)
      IDLE: begin
        if (run) begin
          capture = 1'b1;
          state_d = T1;
        end
      end

      T1: begin
        if (is_alu_op(ir_op_q)) begin
          bus_src[SRC_REG] = 1'b1;
          op_idx           = ir_rx_q;
          load_a           = 1'b1;
          state_d          = T2;
        end else begin
          done    = 1'b1;
          state_d = IDLE;
          case (ir_op_q)
            OP_MV: begin
              bus_src[SRC_REG] = 1'b1;
              rf_we            = 1'b1;
            end
            OP_MVI: begin
              bus_src[SRC_IMM] = 1'b1;
              rf_we            = 1'b1;
            end
            OP_NOP:  ;
            default: ;
          endcase
        end
      end

      T2: begin
        bus_src[SRC_REG] = 1'b1;
        load_g           = 1'b1;
        state_d          = T3;
      end

      T3: begin
        bus_src[SRC_G] = 1'b1;
        rf_we          = 1'b1;
        done           = 1'b1;
        state_d        = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus = ({DATA_W{bus_src[SRC_REG]}} & op_data)
        | ({DATA_W{bus_src[SRC_IMM]}} & ir_imm_q)
        | ({DATA_W{bus_src[SRC_G]}}   & g_q);
  end

  // One extra bit holds the add carry or the subtract borrow.
  always_comb begin
    alu_wide = '0;
    case (alu_op_of(ir_op_q))
      ALU_ADD: alu_wide = {1'b0, a_q} + {1'b0, bus};
      ALU_SUB: alu_wide = {1'b0, a_q} - {1'b0, bus};
      ALU_AND: alu_wide = {1'b0, a_q & bus};
      ALU_OR:  alu_wide = {1'b0, a_q | bus};
      ALU_XOR: alu_wide = {1'b0, a_q ^ bus};
      default: alu_wide = '0;
    endcase
    alu_res = alu_wide[DATA_W-1:0];
    alu_c   = alu_wide[DATA_W];
  end

  always_comb begin
    ir_op_d  = ir_op_q;
    ir_rx_d  = ir_rx_q;
    ir_ry_d  = ir_ry_q;
    ir_imm_d = ir_imm_q;
    a_d      = a_q;
    g_d      = g_q;
    z_d      = z_q;
    c_d      = c_q;

    if (capture) begin
      ir_op_d  = opcode;
      ir_rx_d  = rx;
      ir_ry_d  = ry;
      ir_imm_d = imm;
    end
    if (load_a) begin
      a_d = bus;
    end
    if (load_g) begin
      g_d = alu_res;
      z_d = (alu_res == '0);
      c_d = alu_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ir_op_q  <= '0;
      ir_rx_q  <= '0;
      ir_ry_q  <= '0;
      ir_imm_q <= '0;
      a_q      <= '0;
      g_q      <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_op_q  <= ir_op_d;
      ir_rx_q  <= ir_rx_d;
      ir_ry_q  <= ir_ry_d;
      ir_imm_q <= ir_imm_d;
      a_q      <= a_d;
      g_q      <= g_d;
      z_q      <= z_d;
      c_q      <= c_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign flag_z = z_q;
  assign flag_c = c_q;

endmodule

// File: tb/tb_datapath_seq.sv
// Self-checking bench for datapath_seq: directed scenarios plus a randomized
// instruction stream compared against an arithmetic reference model.
module tb_datapath_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [2:0]  opcode;
  logic [2:0]  rx;
  logic [2:0]  ry;
  logic [15:0] imm;
  logic        busy;
  logic        done;
  logic [15:0] bus;
  logic        flag_z;
  logic        flag_c;
  logic [2:0]  rd_sel;
  logic [15:0] rd_data;

  int checks_total  = 0;
  int checks_passed = 0;

  int          obs_done_cyc;
  logic [15:0] obs_bus [1:6];

  logic [15:0] m_r [8];
  logic        m_z;
  logic        m_c;
  int          exp_lat;
  logic [15:0] exp_bus [1:3];

  datapath_seq dut (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .opcode  (opcode),
    .rx      (rx),
    .ry      (ry),
    .imm     (imm),
    .busy    (busy),
    .done    (done),
    .bus     (bus),
    .flag_z  (flag_z),
    .flag_c  (flag_c),
    .rd_sel  (rd_sel),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Issue one instruction in the next cycle and record bus until done (bounded).
  task automatic run_instr(input logic [2:0] op, input int x, input int y, input logic [15:0] im);
    @(negedge clk);
    run = 1'b1; opcode = op; rx = 3'(x); ry = 3'(y); imm = im;
    @(negedge clk);
    run = 1'b0;
    obs_done_cyc = -1;
    for (int c = 1; c <= 6; c++) begin
      obs_bus[c] = bus;
      if (done) begin
        obs_done_cyc = c;
        break;
      end
      if (c < 6) @(negedge clk);
    end
  endtask

  task automatic read_reg(input int idx, output logic [15:0] v);
    rd_sel = 3'(idx);
    #1;
    v = rd_data;
  endtask

  // Reference model: plain integer arithmetic on a register array.
  task automatic model_exec(input logic [2:0] op, input int x, input int y, input logic [15:0] im);
    int a, b, r;
    a = int'(m_r[x]);
    b = int'(m_r[y]);
    exp_bus[1] = 16'h0; exp_bus[2] = 16'h0; exp_bus[3] = 16'h0;
    case (op)
      3'd0: begin exp_lat = 1; exp_bus[1] = m_r[y]; m_r[x] = m_r[y]; end
      3'd1: begin exp_lat = 1; exp_bus[1] = im; m_r[x] = im; end
      3'd7: begin exp_lat = 1; end
      default: begin
        case (op)
          3'd2:    r = a + b;
          3'd3:    r = a - b;
          3'd4:    r = a & b;
          3'd5:    r = a | b;
          default: r = a ^ b;
        endcase
        if (op == 3'd2)      m_c = (r > 65535);
        else if (op == 3'd3) m_c = (a < b);
        else                 m_c = 1'b0;
        r = r & 32'h0000FFFF;
        m_z = (r == 0);
        exp_lat = 3;
        exp_bus[1] = 16'(a); exp_bus[2] = 16'(b); exp_bus[3] = 16'(r);
        m_r[x] = 16'(r);
      end
    endcase
  endtask

  task automatic test_reset();
    logic [15:0] v;
    rst = 1'b1; run = 1'b0; opcode = 3'd0; rx = 3'd0; ry = 3'd0; imm = 16'h0; rd_sel = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks_total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else checks_passed++;
    checks_total++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else checks_passed++;
    checks_total++; if (bus !== 16'h0) $display("[TB] FAIL reset_bus: got %h expected 0000", bus); else checks_passed++;
    checks_total++; if (flag_z !== 1'b0) $display("[TB] FAIL reset_flag_z: got %b expected 0", flag_z); else checks_passed++;
    checks_total++; if (flag_c !== 1'b0) $display("[TB] FAIL reset_flag_c: got %b expected 0", flag_c); else checks_passed++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      read_reg(i, v);
      checks_total++; if (v !== 16'h0) $display("[TB] FAIL reset_reg%0d: got %h expected 0000", i, v); else checks_passed++;
    end
    // Reset and run on the same edge: reset wins.
    @(negedge clk);
    rst = 1'b1; run = 1'b1; opcode = 3'd1; rx = 3'd2; imm = 16'h5A5A;
    @(negedge clk);
    rst = 1'b0; run = 1'b0;
    checks_total++; if (busy !== 1'b0) $display("[TB] FAIL reset_over_run_busy: got %b expected 0", busy); else checks_passed++;
    @(negedge clk);
    read_reg(2, v);
    checks_total++; if (v !== 16'h0) $display("[TB] FAIL reset_over_run_r2: got %h expected 0000", v); else checks_passed++;
  endtask

  task automatic test_mv_mvi();
    logic [15:0] v;
    run_instr(3'd1, 3, 0, 16'h00A5);
    checks_total++; if (obs_done_cyc !== 1) $display("[TB] FAIL mvi_done_cycle: got %0d expected 1", obs_done_cyc); else checks_passed++;
    checks_total++; if (obs_bus[1] !== 16'h00A5) $display("[TB] FAIL mvi_bus_t1: got %h expected 00a5", obs_bus[1]); else checks_passed++;
    @(negedge clk);
    read_reg(3, v);
    checks_total++; if (v !== 16'h00A5) $display("[TB] FAIL mvi_r3_cycle2: got %h expected 00a5", v); else checks_passed++;
    run_instr(3'd0, 1, 3, 16'hFFFF);
    checks_total++; if (obs_done_cyc !== 1) $display("[TB] FAIL mv_done_cycle: got %0d expected 1", obs_done_cyc); else checks_passed++;
    checks_total++; if (obs_bus[1] !== 16'h00A5) $display("[TB] FAIL mv_bus_t1: got %h expected 00a5", obs_bus[1]); else checks_passed++;
    @(negedge clk);
    read_reg(1, v);
    checks_total++; if (v !== 16'h00A5) $display("[TB] FAIL mv_r1: got %h expected 00a5", v); else checks_passed++;
    read_reg(3, v);
    checks_total++; if (v !== 16'h00A5) $display("[TB] FAIL mv_r3: got %h expected 00a5", v); else checks_passed++;
  endtask

  task automatic test_add_carry();
    logic [15:0] v;
    run_instr(3'd1, 0, 0, 16'hFFFF);
    run_instr(3'd1, 1, 0, 16'h0001);
    run_instr(3'd2, 0, 1, 16'h0000);
    checks_total++; if (obs_done_cyc !== 3) $display("[TB] FAIL add_done_cycle: got %0d expected 3", obs_done_cyc); else checks_passed++;
    checks_total++; if (obs_bus[1] !== 16'hFFFF) $display("[TB] FAIL add_bus_t1: got %h expected ffff", obs_bus[1]); else checks_passed++;
    checks_total++; if (obs_bus[2] !== 16'h0001) $display("[TB] FAIL add_bus_t2: got %h expected 0001", obs_bus[2]); else checks_passed++;
    checks_total++; if (obs_bus[3] !== 16'h0000) $display("[TB] FAIL add_bus_t3: got %h expected 0000", obs_bus[3]); else checks_passed++;
    @(negedge clk);
    read_reg(0, v);
    checks_total++; if (v !== 16'h0000) $display("[TB] FAIL add_r0: got %h expected 0000", v); else checks_passed++;
    checks_total++; if (flag_c !== 1'b1) $display("[TB] FAIL add_flag_c: got %b expected 1", flag_c); else checks_passed++;
    checks_total++; if (flag_z !== 1'b1) $display("[TB] FAIL add_flag_z: got %b expected 1", flag_z); else checks_passed++;
  endtask

  task automatic test_sub_borrow_alias();
    logic [15:0] v;
    run_instr(3'd1, 2, 0, 16'd3);
    run_instr(3'd1, 4, 0, 16'd5);
    run_instr(3'd3, 2, 4, 16'h0);
    @(negedge clk);
    read_reg(2, v);
    checks_total++; if (v !== 16'hFFFE) $display("[TB] FAIL sub_r2: got %h expected fffe", v); else checks_passed++;
    checks_total++; if (flag_c !== 1'b1) $display("[TB] FAIL sub_flag_c: got %b expected 1", flag_c); else checks_passed++;
    checks_total++; if (flag_z !== 1'b0) $display("[TB] FAIL sub_flag_z: got %b expected 0", flag_z); else checks_passed++;
    run_instr(3'd3, 2, 2, 16'h0);
    @(negedge clk);
    read_reg(2, v);
    checks_total++; if (v !== 16'h0000) $display("[TB] FAIL alias_sub_r2: got %h expected 0000", v); else checks_passed++;
    checks_total++; if (flag_z !== 1'b1) $display("[TB] FAIL alias_sub_flag_z: got %b expected 1", flag_z); else checks_passed++;
    checks_total++; if (flag_c !== 1'b0) $display("[TB] FAIL alias_sub_flag_c: got %b expected 0", flag_c); else checks_passed++;
    run_instr(3'd1, 2, 0, 16'h4321);
    run_instr(3'd2, 2, 2, 16'h0);
    @(negedge clk);
    read_reg(2, v);
    checks_total++; if (v !== 16'h8642) $display("[TB] FAIL alias_add_r2: got %h expected 8642", v); else checks_passed++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    run_instr(3'd1, 0, 0, 16'h0003);
    run_instr(3'd1, 1, 0, 16'h0004);
    @(negedge clk);
    run = 1'b1; opcode = 3'd2; rx = 3'd0; ry = 3'd1; imm = 16'h0;
    @(negedge clk);
    checks_total++; if (bus !== 16'h0003) $display("[TB] FAIL b2b_bus_t1: got %h expected 0003", bus); else checks_passed++;
    opcode = 3'd1; rx = 3'd0; ry = 3'd2; imm = 16'hDEAD;
    @(negedge clk);
    checks_total++; if (bus !== 16'h0004) $display("[TB] FAIL b2b_bus_t2: got %h expected 0004", bus); else checks_passed++;
    opcode = 3'd3; rx = 3'd1; ry = 3'd0;
    @(negedge clk);
    checks_total++; if (done !== 1'b1) $display("[TB] FAIL b2b_done_t3: got %b expected 1", done); else checks_passed++;
    checks_total++; if (bus !== 16'h0007) $display("[TB] FAIL b2b_bus_t3: got %h expected 0007", bus); else checks_passed++;
    @(negedge clk);
    checks_total++; if (busy !== 1'b0) $display("[TB] FAIL b2b_idle_busy: got %b expected 0", busy); else checks_passed++;
    opcode = 3'd1; rx = 3'd5; ry = 3'd0; imm = 16'h1234;
    read_reg(0, v);
    checks_total++; if (v !== 16'h0007) $display("[TB] FAIL b2b_r0_cycle4: got %h expected 0007", v); else checks_passed++;
    @(negedge clk);
    run = 1'b0;
    checks_total++; if (done !== 1'b1) $display("[TB] FAIL b2b_next_done: got %b expected 1", done); else checks_passed++;
    checks_total++; if (bus !== 16'h1234) $display("[TB] FAIL b2b_next_bus: got %h expected 1234", bus); else checks_passed++;
    @(negedge clk);
    read_reg(5, v);
    checks_total++; if (v !== 16'h1234) $display("[TB] FAIL b2b_r5: got %h expected 1234", v); else checks_passed++;
    read_reg(1, v);
    checks_total++; if (v !== 16'h0004) $display("[TB] FAIL b2b_r1: got %h expected 0004", v); else checks_passed++;
  endtask

  task automatic test_reset_mid();
    logic [15:0] v;
    run_instr(3'd1, 6, 0, 16'hFFFF);
    run_instr(3'd1, 7, 0, 16'h0001);
    run_instr(3'd2, 6, 7, 16'h0);
    run_instr(3'd1, 6, 0, 16'h0010);
    @(negedge clk);
    run = 1'b1; opcode = 3'd2; rx = 3'd6; ry = 3'd7;
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    checks_total++; if (busy !== 1'b1) $display("[TB] FAIL midrst_busy_t2: got %b expected 1", busy); else checks_passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks_total++; if (busy !== 1'b0) $display("[TB] FAIL midrst_busy: got %b expected 0", busy); else checks_passed++;
    checks_total++; if (done !== 1'b0) $display("[TB] FAIL midrst_done: got %b expected 0", done); else checks_passed++;
    checks_total++; if (bus !== 16'h0) $display("[TB] FAIL midrst_bus: got %h expected 0000", bus); else checks_passed++;
    checks_total++; if (flag_z !== 1'b0) $display("[TB] FAIL midrst_flag_z: got %b expected 0", flag_z); else checks_passed++;
    checks_total++; if (flag_c !== 1'b0) $display("[TB] FAIL midrst_flag_c: got %b expected 0", flag_c); else checks_passed++;
    read_reg(6, v);
    checks_total++; if (v !== 16'h0) $display("[TB] FAIL midrst_r6: got %h expected 0000", v); else checks_passed++;
    @(negedge clk);
    read_reg(6, v);
    checks_total++; if (v !== 16'h0) $display("[TB] FAIL midrst_r6_later: got %h expected 0000", v); else checks_passed++;
    checks_total++; if (busy !== 1'b0) $display("[TB] FAIL midrst_busy_later: got %b expected 0", busy); else checks_passed++;
  endtask

  task automatic test_random();
    logic [15:0] v;
    logic [2:0]  op;
    int          x, y;
    logic [15:0] im;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) m_r[i] = 16'h0;
    m_z = 1'b0; m_c = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (n < 8) begin
        op = 3'd1; x = n;
      end else begin
        op = 3'($urandom_range(0, 7)); x = $urandom_range(0, 7);
      end
      y = $urandom_range(0, 7);
      case ($urandom_range(0, 5))
        0:       im = 16'hFFFF;
        1:       im = 16'h0000;
        default: im = 16'($urandom);
      endcase
      model_exec(op, x, y, im);
      run_instr(op, x, y, im);
      checks_total++; if (obs_done_cyc !== exp_lat) $display("[TB] FAIL rnd%0d_latency op%0d: got %0d expected %0d", n, op, obs_done_cyc, exp_lat); else checks_passed++;
      for (int c = 1; c <= exp_lat; c++) begin
        checks_total++; if (obs_bus[c] !== exp_bus[c]) $display("[TB] FAIL rnd%0d_bus_t%0d op%0d: got %h expected %h", n, c, op, obs_bus[c], exp_bus[c]); else checks_passed++;
      end
      @(negedge clk);
      read_reg(x, v);
      checks_total++; if (v !== m_r[x]) $display("[TB] FAIL rnd%0d_r%0d op%0d: got %h expected %h", n, x, op, v, m_r[x]); else checks_passed++;
      checks_total++; if (flag_z !== m_z) $display("[TB] FAIL rnd%0d_flag_z op%0d: got %b expected %b", n, op, flag_z, m_z); else checks_passed++;
      checks_total++; if (flag_c !== m_c) $display("[TB] FAIL rnd%0d_flag_c op%0d: got %b expected %b", n, op, flag_c, m_c); else checks_passed++;
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      read_reg(i, v);
      checks_total++; if (v !== m_r[i]) $display("[TB] FAIL rnd_final_r%0d: got %h expected %h", i, v, m_r[i]); else checks_passed++;
    end
  endtask

  initial begin
    $display("[TB] datapath_seq bench start");
    test_reset();
    test_mv_mvi();
    test_add_carry();
    test_sub_borrow_alias();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
